threshold_buffer_bank: RTL
==========================

THRESHOLD_BUFFER_BANK -- requirements
Module: threshold_buffer_bank

Interface
REQ-001 NUM_BLOCKS, 8, number of network blocks whose thresholds are held.
REQ-002 DEPTH, 32, threshold words per block.
REQ-003 DATA_WIDTH, 32, bits per threshold word.
REQ-004 ADDR_WIDTH, 8, read/write word-address width; 2**ADDR_WIDTH >= DEPTH SHALL hold (elaboration check).
REQ-005 Derived BLK_W = max(1, clog2(NUM_BLOCKS)).
REQ-006 clk  input  1  single clock, all logic on rising edge.
REQ-007 rst_n  input  1  reset, asynchronous, active-low.
REQ-008 ld_start  input  1  one-cycle pulse, begin loading block ld_blk.
REQ-009 ld_blk  input  BLK_W  block to be loaded, sampled with ld_start.
REQ-010 ld_valid  input  1  ld_data valid.
REQ-011 ld_data  input  DATA_WIDTH  threshold word, written in address order 0..DEPTH-1.
REQ-012 ld_ready  output  1  buffer accepts a load word this cycle.
REQ-013 ld_done  output  1  one-cycle pulse, block load complete.
REQ-014 rd_en  input  1  read request.
REQ-015 rd_blk  input  BLK_W  block selector.
REQ-016 rd_addr  input  ADDR_WIDTH  word address within block.
REQ-017 rd_valid  output  1  rd_data/rd_err valid.
REQ-018 rd_data  output  DATA_WIDTH  threshold word.
REQ-019 rd_err  output  1  request was invalid.
REQ-020 blk_loaded  output  NUM_BLOCKS  bit b = block b holds a complete load.

Function
REQ-021 Storage SHALL be NUM_BLOCKS*DEPTH words, one write port, one read port, physical address = blk*DEPTH + addr.
REQ-022 Load FSM states: IDLE, LOAD, DONE.
REQ-023 IDLE: ld_ready=0; ld_start with ld_blk<NUM_BLOCKS -> LOAD, capture blk, wr_ptr=0, clear blk_loaded[blk]; ld_start with ld_blk>=NUM_BLOCKS ignored.
REQ-024 LOAD: ld_ready=1; each cycle with ld_valid=1 writes ld_data at (blk, wr_ptr), wr_ptr+1; accepting word DEPTH-1 -> DONE.
REQ-025 DONE: ld_ready=0, ld_done=1 for exactly one cycle, blk_loaded[blk] set, -> IDLE.
REQ-026 ld_start outside IDLE SHALL be ignored; ld_valid outside LOAD SHALL be ignored.
REQ-027 Read latency exactly 1: rd_en in cycle n -> rd_valid=1 in cycle n+1 only; back-to-back reads supported every cycle.
REQ-028 Valid request (rd_blk<NUM_BLOCKS, rd_addr<DEPTH, blk_loaded[rd_blk]=1 at cycle n): rd_data = stored word, rd_err=0.
REQ-029 Any other request: rd_valid=1, rd_err=1, rd_data=0; no storage access.
REQ-030 Block under load reads as unloaded (REQ-023 clears its bit); reads of other loaded blocks proceed concurrently with a load.
REQ-031 When rd_en=0, rd_data SHALL hold its last value; rd_valid=0, rd_err=0.
REQ-032 Reloading a loaded block SHALL be legal; its old contents are unreadable from ld_start until ld_done.

Reset
REQ-033 rst_n low: FSM=IDLE, wr_ptr=0, ld_ready=0, ld_done=0, rd_valid=0, rd_err=0, rd_data=0, blk_loaded=0, immediately and asynchronously.
REQ-034 Storage array SHALL NOT be reset; reset mid-load aborts, block stays unloaded.
REQ-035 Release of rst_n is synchronous to clk; first ld_start accepted on the first edge after release.

Structure
REQ-036 Package threshold_buffer_pkg SHALL hold the FSM state type and the clog2/BLK_W helper.
REQ-037 Sub-module threshold_buffer_ram: simple dual-port synchronous RAM, parametrised width/depth, registered read with read enable; no initialisation file.

Verification
REQ-038 Reset, rd_en=1 blk 0 addr 0 -> next cycle rd_valid=1, rd_err=1, rd_data=0, blk_loaded=0.
REQ-039 DEPTH=32: ld_start blk 2, 32 words 0x100+i with ld_valid every cycle -> ld_done 1 cycle after 32nd word, blk_loaded=0x04; read blk 2 addr 5 -> 0x105, rd_err=0.
REQ-040 Load blk 3 with ld_valid toggling 1/0 -> exactly 32 writes, ld_done once, wr_ptr never exceeds 31; rd_addr=32 -> rd_err=1.
REQ-041 During load of blk 4, back-to-back reads of blk 2 addr 0..31 -> 32 consecutive rd_valid, data 0x100..0x11F; read blk 4 -> rd_err=1.
REQ-042 Assert rst_n low after 10 words of blk 5 load -> outputs zero same cycle; after release blk_loaded=0, read blk 5 -> rd_err=1.
REQ-043 Reload blk 2 with 0x200+i; read during load -> rd_err=1; after ld_done addr 7 -> 0x207.

Source files
------------

// File: rtl/threshold_buffer_pkg.sv
// Shared types and elaboration helpers for the threshold buffer bank.
//   ld_state_t : load sequencer states (idle, accepting words, completion pulse)
//   clog2      : ceiling log2 usable in parameter expressions
//   blk_width  : clog2 clamped to at least one bit, for selector/pointer widths
package threshold_buffer_pkg;

    typedef enum logic [1:0] {
        LD_IDLE,
        LD_LOAD,
        LD_DONE
    } ld_state_t;

    function automatic int clog2(input int value);
        int width;
        width = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            width++;
        end
        return width;
    endfunction

    function automatic int blk_width(input int count);
        int width;
        width = clog2(count);
        return (width < 1) ? 1 : width;
    endfunction

endpackage

// File: rtl/threshold_buffer_ram.sv
// Simple dual-port synchronous RAM: one write port, one registered read port.
//   clk     : clock, both ports act on the rising edge
//   wr_en   : write wr_data at wr_addr
//   wr_addr : write word address
//   wr_data : write data
//   rd_en   : capture mem[rd_addr] into rd_data; rd_data holds otherwise
//   rd_addr : read word address
//   rd_data : registered read data (one cycle after rd_en)
module threshold_buffer_ram #(
    parameter int WIDTH = 32,
    parameter int WORDS = 256,
    parameter int AW    = 8
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [WORDS];

    // NOTE: the array has no reset so it maps onto block RAM; validity of its
    // contents is tracked separately by the owner.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/threshold_buffer_bank.sv
// Bank of per-block threshold buffers sharing one RAM.
// A block is loaded word by word in address order; only fully loaded blocks
// are readable, every read answers exactly one cycle later.
//   clk, rst_n              : clock, asynchronous active-low reset
//   ld_start, ld_blk        : begin loading block ld_blk (pulse)
//   ld_valid, ld_data       : load word stream
//   ld_ready                : a load word is accepted this cycle
//   ld_done                 : one-cycle pulse when a block load completes
//   rd_en, rd_blk, rd_addr  : read request
//   rd_valid, rd_data,rd_err: read response (rd_err flags an invalid request)
//   blk_loaded              : per-block "holds a complete load" flags
module threshold_buffer_bank
    import threshold_buffer_pkg::*;
#(
    parameter int  NUM_BLOCKS = 8,
    parameter int  DEPTH      = 32,
    parameter int  DATA_WIDTH = 32,
    parameter int  ADDR_WIDTH = 8,
    localparam int BLK_W      = blk_width(NUM_BLOCKS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ld_start,
    input  logic [BLK_W-1:0]      ld_blk,
    input  logic                  ld_valid,
    input  logic [DATA_WIDTH-1:0] ld_data,
    output logic                  ld_ready,
    output logic                  ld_done,
    input  logic                  rd_en,
    input  logic [BLK_W-1:0]      rd_blk,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  rd_valid,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_err,
    output logic [NUM_BLOCKS-1:0] blk_loaded
);

    localparam int PTR_W     = blk_width(DEPTH);
    localparam int RAM_WORDS = NUM_BLOCKS * DEPTH;
    localparam int RAM_AW    = blk_width(RAM_WORDS);

    if ((2 ** ADDR_WIDTH) < DEPTH) begin : g_addr_width_check
        $error("ADDR_WIDTH too narrow to address DEPTH words");
    end

    ld_state_t             state;
    ld_state_t             state_next;
    logic [BLK_W-1:0]      cur_blk;
    logic [PTR_W-1:0]      wr_ptr;
    logic                  start_ok;
    logic                  word_ok;
    logic                  last_word;
    logic                  rd_ok;
    logic [RAM_AW-1:0]     wr_phys;
    logic [RAM_AW-1:0]     rd_phys;
    logic [DATA_WIDTH-1:0] ram_q;
    logic [DATA_WIDTH-1:0] hold_data;

    assign start_ok  = ld_start && (int'(ld_blk) < NUM_BLOCKS);
    assign word_ok   = (state == LD_LOAD) && ld_valid;
    assign last_word = word_ok && (int'(wr_ptr) == DEPTH - 1);

    // ---------------- load sequencer ----------------
    // NOTE: state and datapath registers use non-blocking assignments so every
    // flop samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= LD_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every output of this block gets a default first, so no path leaves
    // a signal unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        ld_ready   = 1'b0;
        ld_done    = 1'b0;
        unique case (state)
            LD_IDLE: begin
                if (start_ok) state_next = LD_LOAD;
            end
            LD_LOAD: begin
                ld_ready = 1'b1;
                if (last_word) state_next = LD_DONE;
            end
            LD_DONE: begin
                ld_done    = 1'b1;
                state_next = LD_IDLE;
            end
            default: state_next = LD_IDLE;
        endcase
    end

    // The loaded flag drops at load start and rises on the final word, so a
    // block is never readable while partially overwritten.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_blk    <= '0;
            wr_ptr     <= '0;
            blk_loaded <= '0;
        end else begin
            if ((state == LD_IDLE) && start_ok) begin
                cur_blk            <= ld_blk;
                wr_ptr             <= '0;
                blk_loaded[ld_blk] <= 1'b0;
            end
            if (word_ok) begin
                wr_ptr <= last_word ? '0 : wr_ptr + 1'b1;
            end
            if (last_word) begin
                blk_loaded[cur_blk] <= 1'b1;
            end
        end
    end

    assign wr_phys = RAM_AW'(int'(cur_blk) * DEPTH + int'(wr_ptr));

    // ---------------- read path ----------------
    assign rd_ok = rd_en
                && (int'(rd_blk) < NUM_BLOCKS)
                && (int'(rd_addr) < DEPTH)
                && blk_loaded[rd_blk];

    assign rd_phys = RAM_AW'(int'(rd_blk) * DEPTH + int'(rd_addr));

    threshold_buffer_ram #(
        .WIDTH (DATA_WIDTH),
        .WORDS (RAM_WORDS),
        .AW    (RAM_AW)
    ) u_ram (
        .clk     (clk),
        .wr_en   (word_ok),
        .wr_addr (wr_phys),
        .wr_data (ld_data),
        .rd_en   (rd_ok),
        .rd_addr (rd_phys),
        .rd_data (ram_q)
    );

    // hold_data remembers the last presented word so rd_data is stable (and
    // zero after reset) between responses, without resetting the RAM output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid  <= 1'b0;
            rd_err    <= 1'b0;
            hold_data <= '0;
        end else begin
            rd_valid <= rd_en;
            rd_err   <= rd_en && !rd_ok;
            if (rd_valid) begin
                hold_data <= rd_data;
            end
        end
    end

    assign rd_data = !rd_valid ? hold_data :
                     rd_err    ? '0        : ram_q;

endmodule
